// File: rtl/relu_maxpool_requant.sv
// relu_maxpool_requant: captures a full convolution result frame, then walks
// every pooling window one per clock (signed max, ReLU, arithmetic right
// shift, saturation) and assembles the pooled feature map as a parallel bus.
//
// state | meaning
// IDLE  | waiting for a frame, no result held
// POOL  | one window reduced and written per clock
// DONE  | pooled map valid and held until the next frame is accepted
module relu_maxpool_requant #(
    parameter int BITWIDTH    = 8,
    parameter int MAPWIDTH    = 28,
    parameter int MAPHEIGHT   = 28,
    parameter int FILTERBATCH = 6,
    parameter int POOLSIZE    = 2,
    parameter int SHIFT       = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [2*BITWIDTH*FILTERBATCH*MAPHEIGHT*MAPWIDTH-1:0]   in_data,
    output logic                                                   out_valid,
    output logic [BITWIDTH*FILTERBATCH*(MAPHEIGHT/POOLSIZE)*(MAPWIDTH/POOLSIZE)-1:0] out_data,
    output logic                                                   busy
);

    localparam int PW      = MAPWIDTH / POOLSIZE;
    localparam int PH      = MAPHEIGHT / POOLSIZE;
    localparam int IW      = 2 * BITWIDTH;
    localparam int IN_BITS = IW * FILTERBATCH * MAPHEIGHT * MAPWIDTH;

    localparam int B_W  = (FILTERBATCH > 1) ? $clog2(FILTERBATCH) : 1;
    localparam int PR_W = (PH > 1) ? $clog2(PH) : 1;
    localparam int PC_W = (PW > 1) ? $clog2(PW) : 1;

    localparam logic [B_W-1:0]  B_LAST  = B_W'(FILTERBATCH - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(PH - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PW - 1);

    localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (BITWIDTH - 1)) - 1);

    typedef enum logic [1:0] {IDLE, POOL, DONE} stateT;

    stateT                 state;
    stateT                 stateNext;
    logic [IN_BITS-1:0]    capReg;
    logic [B_W-1:0]        bCnt;
    logic [PR_W-1:0]       prCnt;
    logic [PC_W-1:0]       pcCnt;
    logic                  accept;
    logic                  lastWin;
    int                    elemIdx;
    int                    outIdx;
    logic signed [IW-1:0]  elem;
    logic signed [IW-1:0]  winMax;
    logic signed [IW-1:0]  reluVal;
    logic signed [IW-1:0]  shifted;
    logic [BITWIDTH-1:0]   pooled;

    assign lastWin = (bCnt == B_LAST) && (prCnt == PR_LAST) && (pcCnt == PC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next state, handshake and status outputs
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) stateNext = POOL;
            end
            POOL: begin
                busy = 1'b1;
                if (lastWin) stateNext = DONE;
            end
            DONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                accept    = in_valid;
                if (in_valid) stateNext = POOL;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Signed max over the current window, then ReLU, shift and saturate
    always_comb begin
        elemIdx = 0;
        elem    = '0;
        winMax  = '0;
        for (int i = 0; i < POOLSIZE; i++) begin
            for (int j = 0; j < POOLSIZE; j++) begin
                elemIdx = int'(bCnt) * MAPHEIGHT * MAPWIDTH
                        + (int'(prCnt) * POOLSIZE + i) * MAPWIDTH
                        + int'(pcCnt) * POOLSIZE + j;
                elem = capReg[elemIdx*IW +: IW];
                if ((i == 0 && j == 0) || (elem > winMax)) winMax = elem;
            end
        end
        reluVal = winMax[IW-1] ? '0 : winMax;
        shifted = reluVal >>> SHIFT;
        pooled  = (shifted > SAT_MAX) ? SAT_MAX[BITWIDTH-1:0] : shifted[BITWIDTH-1:0];
        outIdx  = int'(bCnt) * PH * PW + int'(prCnt) * PW + int'(pcCnt);
    end

    // Frame capture, window counters and pooled-map assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            capReg   <= '0;
            out_data <= '0;
            bCnt     <= '0;
            prCnt    <= '0;
            pcCnt    <= '0;
        end else if (accept) begin
            capReg <= in_data;
            bCnt   <= '0;
            prCnt  <= '0;
            pcCnt  <= '0;
        end else if (state == POOL) begin
            out_data[outIdx*BITWIDTH +: BITWIDTH] <= pooled;
            if (lastWin) begin
                bCnt  <= '0;
                prCnt <= '0;
                pcCnt <= '0;
            end else if (pcCnt != PC_LAST) begin
                pcCnt <= pcCnt + PC_W'(1);
            end else begin
                pcCnt <= '0;
                if (prCnt != PR_LAST) begin
                    prCnt <= prCnt + PR_W'(1);
                end else begin
                    prCnt <= '0;
                    bCnt  <= bCnt + B_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_requant.sv
// Testbench for relu_maxpool_requant: 4x4 map, 2x2 pooling, shift 2.
// One instance with a single channel, one with two channels.
module tb_relu_maxpool_requant;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         inValid;
    logic [255:0] inData;
    logic         inReady;
    logic         outValid;
    logic [31:0]  outData;
    logic         busy;

    logic         inValidM;
    logic [511:0] inDataM;
    logic         inReadyM;
    logic         outValidM;
    logic [63:0]  outDataM;
    logic         busyM;

    relu_maxpool_requant #(
        .BITWIDTH(8), .MAPWIDTH(4), .MAPHEIGHT(4),
        .FILTERBATCH(1), .POOLSIZE(2), .SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_data(inData), .out_valid(outValid), .out_data(outData), .busy(busy)
    );

    relu_maxpool_requant #(
        .BITWIDTH(8), .MAPWIDTH(4), .MAPHEIGHT(4),
        .FILTERBATCH(2), .POOLSIZE(2), .SHIFT(2)
    ) dutMc (
        .clk(clk), .rst(rst), .in_valid(inValidM), .in_ready(inReadyM),
        .in_data(inDataM), .out_valid(outValidM), .out_data(outDataM), .busy(busyM)
    );

    int nTests = 0;
    int nFail  = 0;

    logic [63:0] expQ[$];
    logic [63:0] expQM[$];

    int relTbl [16] = '{-100, -100, 1000, 5,
                        -100, -100,    5, 5,
                           3,   -7,  508, -200,
                           1,    0,  100, 7};

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: r*4+c, 1: ReLU/saturation table, 2: all 40, 3: all 1000, else -(r*4+c)
    function automatic logic [255:0] packFrame(input int mode);
        logic [255:0] f;
        int v;
        f = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (mode)
                    0:       v = r * 4 + c;
                    1:       v = relTbl[r*4+c];
                    2:       v = 40;
                    3:       v = 1000;
                    default: v = -(r * 4 + c);
                endcase
                f[(r*4+c)*16 +: 16] = 16'(v);
            end
        end
        return f;
    endfunction

    // Cycle counting, acceptance time and busy duration for both instances
    int cyc = 0;
    int accCyc = 0;
    int busyCnt = 0;
    int accCycM = 0;
    int busyCntM = 0;
    logic prevOv = 1'b0;
    logic prevOvM = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && inValid && inReady) begin
            accCyc  <= cyc + 1;
            busyCnt <= 0;
        end else if (busy) begin
            busyCnt <= busyCnt + 1;
        end
        if (!rst && inValidM && inReadyM) begin
            accCycM  <= cyc + 1;
            busyCntM <= 0;
        end else if (busyM) begin
            busyCntM <= busyCntM + 1;
        end
    end

    // Scoreboard: on each rising out_valid pop the expected map and compare
    always @(negedge clk) begin
        if (outValid && !prevOv) begin
            if (expQ.size() == 0) begin
                checkVal("unexpectedValid", 64'(outValid), 64'd0);
            end else begin
                checkVal("latency", 64'(cyc - accCyc), 64'd4);
                checkVal("busyCycles", 64'(busyCnt), 64'd4);
                checkVal("frameData", 64'(outData), expQ.pop_front());
            end
        end
        if (outValidM && !prevOvM) begin
            if (expQM.size() == 0) begin
                checkVal("unexpectedValidMc", 64'(outValidM), 64'd0);
            end else begin
                checkVal("latencyMc", 64'(cyc - accCycM), 64'd8);
                checkVal("busyCyclesMc", 64'(busyCntM), 64'd8);
                checkVal("frameDataMc", outDataM, expQM.pop_front());
            end
        end
        prevOv  <= outValid;
        prevOvM <= outValidM;
    end

    task automatic sendFrame(input logic [255:0] d, input logic [31:0] expVal, input bit doPush);
        @(posedge clk);
        #1;
        inData  = d;
        inValid = 1'b1;
        if (doPush) expQ.push_back(64'(expVal));
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && !outValid; i++) @(negedge clk);
        checkVal("doneSeen", 64'(outValid), 64'd1);
    endtask

    task automatic waitDoneM(input int budget);
        for (int i = 0; i < budget && !outValidM; i++) @(negedge clk);
        checkVal("doneSeenMc", 64'(outValidM), 64'd1);
    endtask

    initial begin
        rst      = 1'b1;
        inValid  = 1'b1;
        inData   = packFrame(0);
        inValidM = 1'b0;
        inDataM  = '0;

        // Reset held two cycles while in_valid is high
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rstOutValid", 64'(outValid), 64'd0);
        checkVal("rstOutData", 64'(outData), 64'd0);
        checkVal("rstInReady", 64'(inReady), 64'd1);
        checkVal("rstBusy", 64'(busy), 64'd0);
        rst     = 1'b0;
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("noAcceptValid", 64'(outValid), 64'd0);
        checkVal("noAcceptBusy", 64'(busy), 64'd0);

        // Basic frame
        sendFrame(packFrame(0), 32'h03030101, 1'b1);
        waitDone(12);
        repeat (3) @(negedge clk);
        checkVal("doneHoldValid", 64'(outValid), 64'd1);
        checkVal("doneHoldData", 64'(outData), 64'h03030101);

        // ReLU and saturation
        sendFrame(packFrame(1), 32'h7f007f00, 1'b1);
        waitDone(12);

        // Back-to-back from DONE with in_valid held through POOL
        @(posedge clk);
        #1;
        inData  = packFrame(2);
        inValid = 1'b1;
        expQ.push_back(64'h0a0a0a0a);
        @(posedge clk);
        @(negedge clk);
        checkVal("b2bDropValid", 64'(outValid), 64'd0);
        checkVal("b2bBusy", 64'(busy), 64'd1);
        checkVal("poolInReady", 64'(inReady), 64'd0);
        inData = packFrame(3);
        repeat (3) @(posedge clk);
        #1;
        inValid = 1'b0;
        waitDone(12);

        // Reset two cycles into POOL aborts the frame
        sendFrame(packFrame(0), 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkVal("midRstValid", 64'(outValid), 64'd0);
        checkVal("midRstData", 64'(outData), 64'd0);
        checkVal("midRstBusy", 64'(busy), 64'd0);
        checkVal("midRstReady", 64'(inReady), 64'd1);
        repeat (6) @(negedge clk);
        checkVal("midRstStayLow", 64'(outValid), 64'd0);
        sendFrame(packFrame(0), 32'h03030101, 1'b1);
        waitDone(12);

        // Two channels, second one negated
        @(posedge clk);
        #1;
        inDataM  = {packFrame(4), packFrame(0)};
        inValidM = 1'b1;
        expQM.push_back(64'h00000000_03030101);
        @(posedge clk);
        #1;
        inValidM = 1'b0;
        waitDoneM(20);

        repeat (2) @(negedge clk);
        checkVal("queueDrained", 64'(expQ.size()), 64'd0);
        checkVal("queueDrainedMc", 64'(expQM.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/relu_maxpool_requant.md
Name: relu_maxpool_requant

Overview:
- Stage directly downstream of the convolution block.
- Captures the full parallel convolution result bus (2*BITWIDTH signed values per output pixel, all filter batches) on a valid/ready handshake.
- Walks every pooling window sequentially, one pooled value per clock: max over the window, ReLU, right-shift requantization and saturation back to BITWIDTH.
- Assembles a parallel feature-map bus in the same channel/row/col packing the next convolution's data input expects.

Parameters:
- BITWIDTH, 8: output element width; input elements are 2*BITWIDTH wide, signed two's complement.
- MAPWIDTH, 28: input feature map width (convolution output width).
- MAPHEIGHT, 28: input feature map height.
- FILTERBATCH, 6: number of input channels (convolution filter batches).
- POOLSIZE, 2: square pooling window size; stride equals POOLSIZE.
- SHIFT, 4: arithmetic right shift applied after ReLU; 0 is legal.
- Derived values:
  - PW = MAPWIDTH/POOLSIZE (floor).
  - PH = MAPHEIGHT/POOLSIZE (floor).
  - N = FILTERBATCH*PH*PW.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a complete convolution result.
- in_ready  output  1  block can accept a frame.
- in_data  input  2*BITWIDTH*FILTERBATCH*MAPHEIGHT*MAPWIDTH  element (b,r,c) at bit offset (b*MAPHEIGHT*MAPWIDTH + r*MAPWIDTH + c)*2*BITWIDTH.
- out_valid  output  1  out_data holds a complete pooled map.
- out_data  output  BITWIDTH*N  element (b,r,c) at bit offset (b*PH*PW + r*PW + c)*BITWIDTH.
- busy  output  1  high while windows are being processed.

Behaviour:
- Reset (synchronous, active-high, on clk rising edge):
  - state=IDLE, out_valid=0, out_data=0, busy=0, in_ready=1.
  - All counters and the capture register are cleared.
- States:
  - IDLE: in_ready=1, busy=0, out_valid=0.
  - POOL: in_ready=0, busy=1.
  - DONE: in_ready=1, busy=0, out_valid=1, out_data stable.
- Acceptance:
  - A frame is accepted on any edge where in_valid && in_ready.
  - in_data is copied into an internal capture register; the window counters (b,pr,pc) are set to (0,0,0); next state is POOL.
  - Accepting in DONE drops out_valid on that same edge. out_data keeps its old contents until each element is overwritten.
- POOL, one window per edge, counter order pc fastest, then pr, then b:
  - Read the POOLSIZE*POOLSIZE signed values at rows pr*POOLSIZE..+POOLSIZE-1 and cols pc*POOLSIZE..+POOLSIZE-1 of channel b.
  - m = signed max of the window.
  - v = (m<0) ? 0 : m, then v = v >>> SHIFT (truncation).
  - Saturate: if v > 2^(BITWIDTH-1)-1, output 2^(BITWIDTH-1)-1, so the output is non-negative signed BITWIDTH.
  - Write the result to out_data element (b,pr,pc).
  - The max tree is combinational within the cycle; there is no pipelining inside POOL.
- Completion:
  - On the edge that writes window N-1, state becomes DONE and out_valid=1.
  - Latency from the accepting edge to out_valid visible is exactly N cycles.
- DONE is held indefinitely until a new frame is accepted; there is no out_ready.
- Incomplete windows: when MAPWIDTH or MAPHEIGHT is not a multiple of POOLSIZE, trailing rows/cols are ignored.
- in_valid during POOL is ignored; in_ready=0 there.
- Reset mid-POOL aborts the frame and clears out_data; no partial out_valid.
- Widths: counters sized by $clog2 of their range (minimum 1 bit); no internal overflow is possible.

Test Plan:
Bench config for all scenarios: BITWIDTH=8, MAPWIDTH=4, MAPHEIGHT=4, FILTERBATCH=1, POOLSIZE=2, SHIFT=2, so N=4.
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1, busy=0; no frame accepted.
- Basic frame:
  - Stimulus: element value = r*4+c (0..15), in_valid pulsed 1 cycle.
  - Window maxima are 5, 7, 13, 15, giving outputs 1, 1, 3, 3.
  - Required: out_data = {8'd3, 8'd3, 8'd1, 8'd1} (MSB..LSB); out_valid rises exactly 4 cycles after acceptance; busy high for those 4 cycles.
- ReLU and saturation:
  - Stimulus: window 0 all -100; window 1 contains 16'sd1000 (>>2=250); window 2 max 16'sd3; window 3 max 16'sd508.
  - Required outputs: 0, 127, 0, 127.
- Back-to-back:
  - Stimulus: hold in_valid high with a second frame (all 40) from DONE.
  - Required: out_valid drops on the accepting edge; after 4 cycles out_valid=1 with every element = 10; in_valid during POOL causes no re-capture.
- Reset mid-operation: assert rst 2 cycles after acceptance -> next cycle state IDLE, out_data=0, out_valid stays 0; a following frame completes normally.
- Multi-channel: FILTERBATCH=2, channel 1 = channel 0 negated (values -(r*4+c)) -> channel 0 outputs 1, 1, 3, 3; channel 1 outputs all 0; out_valid after 8 cycles.
